// File: rtl/ram8_arbiter.sv
// Two-port arbiter/sequencer in front of one 8 x 16-bit RAM (sync write, comb read).
// Ports A and B issue read/write commands over valid/ready and collect the result over
// a per-port response valid/ready handshake. One command is in flight at a time:
// IDLE (arbitrate/accept) -> ACCESS (drive RAM) -> RESP (hold result until consumed).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   a_req_valid/ready/we/addr/wdata port A command channel
//   a_rsp_valid/ready/rdata         port A response channel (read data or echoed wdata)
//   b_*                             identical set for port B
//   ram_in/ram_load/ram_address     drive the RAM; this block is the sole owner of ram_load
//   ram_out                         combinational RAM read data
//
// Build option: define RAM8_ARB_FIXED_PRIO_EN for fixed priority (A always wins
// contention). Default build is round-robin between A and B.

module ram8_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    input  logic              a_rsp_ready,
    output logic [DATA_W-1:0] a_rsp_rdata,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    input  logic              b_rsp_ready,
    output logic [DATA_W-1:0] b_rsp_rdata,

    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;   // 0 = A, 1 = B
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    // a_pick: A is the winner this cycle (only meaningful in IDLE).
    logic                a_pick;
    logic                a_acc;
    logic                b_acc;

`ifdef RAM8_ARB_FIXED_PRIO_EN
    always_comb begin
        a_pick = a_req_valid;
    end
`else
    // last_b_q = 1 means B was granted most recently, so A wins the next tie.
    logic                last_b_q, last_b_d;

    always_comb begin
        a_pick = a_req_valid & (~b_req_valid | last_b_q);
    end

    always_comb begin
        last_b_d = last_b_q;
        if (a_acc) begin
            last_b_d = 1'b0;
        end else if (b_acc) begin
            last_b_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end
`endif

    assign a_acc = a_req_valid & a_req_ready;
    assign b_acc = b_req_valid & b_req_ready;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        a_req_ready = 1'b0;
        b_req_ready = 1'b0;
        a_rsp_valid = 1'b0;
        b_rsp_valid = 1'b0;
        ram_load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                a_req_ready = a_pick;
                b_req_ready = b_req_valid & ~a_pick;
                if (a_req_valid & a_pick) begin
                    owner_d = 1'b0;
                    we_d    = a_req_we;
                    addr_d  = a_req_addr;
                    wdata_d = a_req_wdata;
                    state_d = ACCESS;
                end else if (b_req_valid) begin
                    owner_d = 1'b1;
                    we_d    = b_req_we;
                    addr_d  = b_req_addr;
                    wdata_d = b_req_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Write commits at the edge ending this cycle; the response
                // is captured at the same edge.
                ram_load = we_q;
                rdata_d  = we_q ? wdata_q : ram_out;
                state_d  = RESP;
            end
            RESP: begin
                a_rsp_valid = ~owner_q;
                b_rsp_valid = owner_q;
                if (owner_q ? b_rsp_ready : a_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Address/data are driven from the latched command so they hold their
    // last value outside ACCESS; only ram_load is qualified by state.
    assign ram_address = addr_q;
    assign ram_in      = wdata_q;
    assign a_rsp_rdata = rdata_q;
    assign b_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ram8_arbiter.sv
// Self-checking bench for ram8_arbiter with a behavioural RAM and reference model.
// Scenario tasks run in sequence; each compares DUT behaviour against bench-side expectations.

module tb_ram8_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_req_valid, a_req_ready, a_req_we;
    logic [2:0]  a_req_addr;
    logic [15:0] a_req_wdata;
    logic        a_rsp_valid, a_rsp_ready;
    logic [15:0] a_rsp_rdata;
    logic        b_req_valid, b_req_ready, b_req_we;
    logic [2:0]  b_req_addr;
    logic [15:0] b_req_wdata;
    logic        b_rsp_valid, b_rsp_ready;
    logic [15:0] b_rsp_rdata;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [2:0]  ram_address;
    logic [15:0] ram_out;

    int checks;
    int failures;

    ram8_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_req_valid (a_req_valid),
        .a_req_ready (a_req_ready),
        .a_req_we    (a_req_we),
        .a_req_addr  (a_req_addr),
        .a_req_wdata (a_req_wdata),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_ready (a_rsp_ready),
        .a_rsp_rdata (a_rsp_rdata),
        .b_req_valid (b_req_valid),
        .b_req_ready (b_req_ready),
        .b_req_we    (b_req_we),
        .b_req_addr  (b_req_addr),
        .b_req_wdata (b_req_wdata),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_ready (b_rsp_ready),
        .b_rsp_rdata (b_rsp_rdata),
        .ram_in      (ram_in),
        .ram_load    (ram_load),
        .ram_address (ram_address),
        .ram_out     (ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The RAM itself: sync write, combinational read, zero at power-up.
    logic [15:0] mem [8] = '{default: 16'h0000};
    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_in;
    end
    assign ram_out = mem[ram_address];

    // ram_load monitor (sampled mid-cycle).
    int          load_cnt = 0;
    logic [2:0]  load_addr = '0;
    always @(negedge clk) begin
        if (ram_load) begin
            load_cnt  <= load_cnt + 1;
            load_addr <= ram_address;
        end
    end

    // Reference model: memory image and round-robin pointer.
    logic [15:0] ref_mem [8];
    bit          model_last_b;

    task automatic apply_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_last_b = 1'b1;
    endtask

    // Drives one command on port p with rsp_ready already high; returns the
    // response data, the cycle latency from accept, and the other port's rsp_valid.
    task automatic op(input bit p, input bit we, input logic [2:0] ad,
                      input logic [15:0] wd, output logic [15:0] rd,
                      output int lat, output bit other_v, output bit ok);
        bit got;
        ok = 1'b1;
        rd = '0;
        lat = 0;
        other_v = 1'b0;
        if (p) begin
            b_req_we = we; b_req_addr = ad; b_req_wdata = wd; b_req_valid = 1'b1;
        end else begin
            a_req_we = we; a_req_addr = ad; a_req_wdata = wd; a_req_valid = 1'b1;
        end
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = p ? b_req_ready : a_req_ready;
        end
        if (!got) begin
            ok = 1'b0;
            a_req_valid = 1'b0;
            b_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // Scramble fields after the handshake; they must not matter.
        if (p) begin
            b_req_valid = 1'b0; b_req_addr = 3'($urandom); b_req_wdata = 16'($urandom);
            b_req_we = 1'($urandom);
        end else begin
            a_req_valid = 1'b0; a_req_addr = 3'($urandom); a_req_wdata = 16'($urandom);
            a_req_we = 1'($urandom);
        end
        model_last_b = p;
        if (we) ref_mem[ad] = wd;
        lat = 1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = p ? b_rsp_valid : a_rsp_valid;
            if (!got) lat++;
        end
        if (!got) begin
            ok = 1'b0;
            return;
        end
        rd = p ? b_rsp_rdata : a_rsp_rdata;
        other_v = p ? a_rsp_valid : b_rsp_valid;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_rsp_ready = 1;
        b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_rsp_ready = 1;
        for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0000;
        #1 rst_n = 1'b0;
        #11;
        checks++;
        if ({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ram_load} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ram_load});
        end
        checks++;
        if ({ram_in, ram_address, a_rsp_rdata, b_rsp_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_data: got in=%h addr=%h ra=%h rb=%h want zeros",
                     ram_in, ram_address, a_rsp_rdata, b_rsp_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_last_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_empty_read();
        logic [15:0] rd; int lat; bit ov, ok;
        op(1'b1, 1'b0, 3'd7, 16'hDEAD, rd, lat, ov, ok);
        checks++;
        if ({ok, lat[3:0], rd, ov} !== {1'b1, 4'd2, 16'h0000, 1'b0}) begin
            failures++;
            $display("FAIL empty_read: got ok=%0d lat=%0d rd=%h aval=%0d want 1 2 0000 0",
                     ok, lat, rd, ov);
        end
    endtask

    task automatic test_write_read();
        logic [15:0] rd; int lat; bit ov, ok; int c0;
        c0 = load_cnt;
        op(1'b0, 1'b1, 3'd3, 16'h3333, rd, lat, ov, ok);
        checks++;
        if ({ok, lat[3:0], rd, ov} !== {1'b1, 4'd2, 16'h3333, 1'b0}) begin
            failures++;
            $display("FAIL wr3_rsp: got ok=%0d lat=%0d rd=%h bval=%0d want 1 2 3333 0",
                     ok, lat, rd, ov);
        end
        checks++;
        if (load_cnt - c0 != 1 || load_addr !== 3'd3) begin
            failures++;
            $display("FAIL wr3_load: got loads=%0d addr=%0d want 1 3", load_cnt - c0, load_addr);
        end
        c0 = load_cnt;
        op(1'b0, 1'b0, 3'd3, 16'h0BAD, rd, lat, ov, ok);
        checks++;
        if ({ok, lat[3:0], rd} !== {1'b1, 4'd2, 16'h3333}) begin
            failures++;
            $display("FAIL rd3: got ok=%0d lat=%0d rd=%h want 1 2 3333", ok, lat, rd);
        end
        checks++;
        if (load_cnt != c0) begin
            failures++;
            $display("FAIL rd3_load: got loads=%0d want 0", load_cnt - c0);
        end
    endtask

    task automatic test_contention();
        bit exp_b, got;
        apply_reset();
        a_req_we = 1; a_req_addr = 3'd1; a_req_wdata = 16'h001F; a_req_valid = 1;
        b_req_we = 1; b_req_addr = 3'd2; b_req_wdata = 16'h3039; b_req_valid = 1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) a_req_valid = 1'b0;
`ifdef RAM8_ARB_FIXED_PRIO_EN
            exp_b = (k == 4);
`else
            exp_b = (k == 4) ? 1'b1 : ~model_last_b;
`endif
            got = 1'b0;
            for (int n = 0; n < 20 && !got; n++) begin
                @(negedge clk);
                got = a_req_ready | b_req_ready;
            end
            checks++;
            if ({a_req_ready, b_req_ready} !== (exp_b ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL grant%0d: got a=%0d b=%0d want b=%0d",
                         k, a_req_ready, b_req_ready, exp_b);
            end
            if (!got) break;
            model_last_b = exp_b;
            if (exp_b) ref_mem[2] = 16'h3039;
            else       ref_mem[1] = 16'h001F;
            @(posedge clk);
            got = 1'b0;
            for (int n = 0; n < 20 && !got; n++) begin
                @(negedge clk);
                got = exp_b ? b_rsp_valid : a_rsp_valid;
            end
            checks++;
            if (!got || (exp_b ? b_rsp_rdata : a_rsp_rdata) !== (exp_b ? 16'h3039 : 16'h001F)) begin
                failures++;
                $display("FAIL grant%0d_rsp: got valid=%0d data=%h", k, got,
                         exp_b ? b_rsp_rdata : a_rsp_rdata);
            end
            @(posedge clk);
            #1;
        end
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        bit got;
        a_rsp_ready = 1'b0;
        a_req_we = 0; a_req_addr = 3'd1; a_req_valid = 1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = a_req_ready;
        end
        @(posedge clk);
        #1;
        a_req_valid = 0;
        b_req_we = 0; b_req_addr = 3'd2; b_req_valid = 1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = a_rsp_valid;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({a_rsp_valid, a_rsp_rdata, b_req_ready, b_rsp_valid} !==
                {1'b1, ref_mem[1], 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold%0d: got av=%0d ad=%h brdy=%0d bv=%0d want 1 %h 0 0",
                         i, a_rsp_valid, a_rsp_rdata, b_req_ready, b_rsp_valid, ref_mem[1]);
            end
        end
        @(posedge clk);
        #1 a_rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (b_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_release_early: got b_req_ready=%0d want 0", b_req_ready);
        end
        @(negedge clk);
        checks++;
        if ({a_rsp_valid, b_req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_b_grant: got av=%0d brdy=%0d want 0 1", a_rsp_valid, b_req_ready);
        end
        model_last_b = 1'b1;
        @(posedge clk);
        #1 b_req_valid = 0;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = b_rsp_valid;
        end
        checks++;
        if (!got || b_rsp_rdata !== ref_mem[2]) begin
            failures++;
            $display("FAIL bp_b_rsp: got valid=%0d data=%h want %h", got, b_rsp_rdata, ref_mem[2]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] rd; int lat; bit ov, ok, got; int c0;
        c0 = load_cnt;
        a_req_we = 1; a_req_addr = 3'd5; a_req_wdata = 16'h56CE; a_req_valid = 1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = a_req_ready;
        end
        @(posedge clk);
        #2;
        a_req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ram_load, ram_in, ram_address}
            !== '0) begin
            failures++;
            $display("FAIL midrst_out: got load=%0d in=%h addr=%0d av=%0d bv=%0d want zeros",
                     ram_load, ram_in, ram_address, a_rsp_valid, b_rsp_valid);
        end
        #1 rst_n = 1'b1;
        model_last_b = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (load_cnt != c0) begin
            failures++;
            $display("FAIL midrst_load: got loads=%0d want 0", load_cnt - c0);
        end
        op(1'b1, 1'b0, 3'd5, 16'h0, rd, lat, ov, ok);
        checks++;
        if ({ok, rd} !== {1'b1, ref_mem[5]}) begin
            failures++;
            $display("FAIL midrst_rd5: got ok=%0d rd=%h want %h", ok, rd, ref_mem[5]);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] rd; int lat; bit ov, ok; logic [15:0] e;
        for (int i = 0; i < 8; i++) begin
            e = 16'(i * 16'h1111);
            op(1'b0, 1'b1, 3'(i), e, rd, lat, ov, ok);
        end
        for (int i = 0; i < 8; i++) begin
            e = 16'(i * 16'h1111);
            op(1'(i % 2), 1'b0, 3'(i), 16'hFFFF, rd, lat, ov, ok);
            checks++;
            if ({ok, lat[3:0], rd, ov} !== {1'b1, 4'd2, e, 1'b0}) begin
                failures++;
                $display("FAIL sweep_rd%0d: got ok=%0d lat=%0d rd=%h ov=%0d want %h",
                         i, ok, lat, rd, ov, e);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] rd, e, wd; int lat; bit ov, ok, p, we; logic [2:0] ad;
        for (int k = 0; k < 30; k++) begin
            p  = 1'($urandom);
            we = 1'($urandom);
            ad = 3'($urandom);
            wd = 16'($urandom);
            e  = we ? wd : ref_mem[ad];
            op(p, we, ad, wd, rd, lat, ov, ok);
            checks++;
            if ({ok, lat[3:0], rd, ov} !== {1'b1, 4'd2, e, 1'b0}) begin
                failures++;
                $display("FAIL rand%0d: port=%0d we=%0d addr=%0d got ok=%0d lat=%0d rd=%h want %h",
                         k, p, we, ad, ok, lat, rd, e);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_empty_read();
        test_write_read();
        test_contention();
        test_backpressure();
        test_reset_mid_access();
        test_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
